// File: rtl/systolic_array_pp.sv
// NxN output-stationary systolic matrix multiplier with double-banked operand SRAMs.
// Optional saturating accumulation and overflow flag: define SYSTOLIC_SAT_EN.
module systolic_array_pp #(
  parameter int unsigned N    = 16,
  parameter int unsigned DW   = 8,
  parameter int unsigned ACCW = 16,
  localparam int unsigned AW  = $clog2(N*N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_a,
  input  logic [AW-1:0]   addr_a,
  input  logic [DW-1:0]   din_a,
  input  logic            we_b,
  input  logic [AW-1:0]   addr_b,
  input  logic [DW-1:0]   din_b,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            load_bank,
  input  logic [AW-1:0]   c_addr,
  output logic [ACCW-1:0] c_data,
  output logic            ovf
);
  localparam int unsigned NN    = N*N;
  localparam int unsigned STEPS = 3*N;
  localparam int unsigned CW    = $clog2(STEPS);
  localparam int unsigned PW    = 2*DW;
  localparam int unsigned SW    = ((ACCW > PW) ? ACCW : PW) + 1;
  localparam logic [CW-1:0] LAST    = CW'(STEPS-1);
  localparam logic [SW-1:0] ACC_MAX = SW'({ACCW{1'b1}});

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            cbank;
  logic            accept;
  logic            last_step;
  logic [DW-1:0]   mem_a [2][NN];
  logic [DW-1:0]   mem_b [2][NN];
  logic [DW-1:0]   a_feed [N];
  logic [DW-1:0]   b_feed [N];
  logic [DW-1:0]   a_sh [N][N];
  logic [DW-1:0]   b_sh [N][N];
  logic [ACCW-1:0] acc [N][N];
  logic [ACCW-1:0] acc_nxt [N][N];
  logic [ACCW-1:0] res [NN];
`ifdef SYSTOLIC_SAT_EN
  logic            sat_any;
  logic            sat_seen;
`endif

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == COMPUTE) && (cnt == LAST);

  // Operand banks are never reset so loaded data survives an aborted run.
  always_ff @(posedge clk) begin
    if (we_a && (32'(addr_a) < NN)) mem_a[load_bank][addr_a] <= din_a;
    if (we_b && (32'(addr_b) < NN)) mem_b[load_bank][addr_b] <= din_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cbank     <= 1'b0;
      load_bank <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= COMPUTE;
          cnt       <= '0;
          cbank     <= load_bank;
          load_bank <= ~load_bank;
          busy      <= 1'b1;
        end
        COMPUTE: if (cnt == LAST) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skewed edge feed: row i / column j reads element cnt-i / cnt-j, zero outside the window.
  always_comb begin
    int k;
    k = 0;
    for (int i = 0; i < int'(N); i++) begin
      k = int'(cnt) - i;
      a_feed[i] = (k >= 0 && k < int'(N)) ? mem_a[cbank][AW'(i*int'(N) + k)] : '0;
      b_feed[i] = (k >= 0 && k < int'(N)) ? mem_b[cbank][AW'(k*int'(N) + i)] : '0;
    end
  end

  always_comb begin
    logic [PW-1:0] prod;
    logic [SW-1:0] sum;
    prod = '0;
    sum  = '0;
`ifdef SYSTOLIC_SAT_EN
    sat_any = 1'b0;
`endif
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        prod = PW'(a_sh[i][j]) * PW'(b_sh[i][j]);
        sum  = SW'(acc[i][j]) + SW'(prod);
`ifdef SYSTOLIC_SAT_EN
        if (sum > ACC_MAX) begin
          acc_nxt[i][j] = '1;
          sat_any       = 1'b1;
        end else begin
          acc_nxt[i][j] = ACCW'(sum);
        end
`else
        acc_nxt[i][j] = ACCW'(sum);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(N); j++) begin
          a_sh[i][j] <= '0;
          b_sh[i][j] <= '0;
          acc[i][j]  <= '0;
        end
      end
      for (int n = 0; n < int'(NN); n++) res[n] <= '0;
      c_data <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < int'(N); i++) begin
          for (int j = 0; j < int'(N); j++) begin
            a_sh[i][j] <= '0;
            b_sh[i][j] <= '0;
            acc[i][j]  <= '0;
          end
        end
      end else if (state == COMPUTE) begin
        for (int i = 0; i < int'(N); i++) begin
          a_sh[i][0] <= a_feed[i];
          b_sh[0][i] <= b_feed[i];
          for (int j = 0; j < int'(N) - 1; j++) begin
            a_sh[i][j+1] <= a_sh[i][j];
            b_sh[j+1][i] <= b_sh[j][i];
          end
          for (int j = 0; j < int'(N); j++) begin
            acc[i][j] <= acc_nxt[i][j];
            // Accumulators are already final on the last step; snapshot them here.
            if (cnt == LAST) res[i*int'(N) + j] <= acc[i][j];
          end
        end
      end
      c_data <= (32'(c_addr) < NN) ? res[c_addr] : '0;
    end
  end

`ifdef SYSTOLIC_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      sat_seen <= 1'b0;
    end else if (accept) begin
      ovf      <= 1'b0;
      sat_seen <= 1'b0;
    end else if (state == COMPUTE) begin
      if (sat_any) sat_seen <= 1'b1;
      if (last_step) ovf <= sat_seen | sat_any;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_array_pp.sv
// Self-checking bench for systolic_array_pp (N=4, DW=8, ACCW=16); model is plain matrix arithmetic.
module tb_systolic_array_pp;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int ACCW = 16;
  localparam int AW   = 4;
  localparam int NN   = N*N;

  logic            clk;
  logic            rst;
  logic            we_a, we_b, start;
  logic [AW-1:0]   addr_a, addr_b, c_addr;
  logic [DW-1:0]   din_a, din_b;
  logic            busy, done, load_bank, ovf;
  logic [ACCW-1:0] c_data;

  systolic_array_pp #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .start(start),
    .busy(busy), .done(done), .load_bank(load_bank), .c_addr(c_addr),
    .c_data(c_data), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;
  int ma [2][NN];
  int mb [2][NN];
  int lb;
  int mres [NN];
  int movf;
  int pend [NN];
  int pend_ovf;
  int pa [NN];
  int pb [NN];

  typedef struct {
    int kind;
    int probe;
    int exp_probe;
    int exp_ovf;
  } vec_t;
  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  // Reference: C = A x B over the whole bank, wrapped or clamped at 2^ACCW-1.
  task automatic model_result(input int bank);
    int s;
    pend_ovf = 0;
    for (int idx = 0; idx < NN; idx++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += ma[bank][(idx/N)*N + k] * mb[bank][k*N + idx%N];
`ifdef SYSTOLIC_SAT_EN
      if (s > 65535) begin
        pend[idx] = 65535;
        pend_ovf  = 1;
      end else begin
        pend[idx] = s;
      end
`else
      pend[idx] = s % 65536;
`endif
    end
  endtask

  task automatic fill_pattern(input int kind);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (kind)
          0: begin pa[r*N+c] = r + 1;               pb[r*N+c] = c + 1; end
          1: begin pa[r*N+c] = 255;                 pb[r*N+c] = 255;   end
          2: begin pa[r*N+c] = (r == c) ? 1 : 0;    pb[r*N+c] = c + 1; end
          3: begin pa[r*N+c] = 1;                   pb[r*N+c] = r + 1; end
          4: begin pa[r*N+c] = $urandom_range(0, 15); pb[r*N+c] = $urandom_range(0, 15); end
          default: begin pa[r*N+c] = $urandom_range(0, 255); pb[r*N+c] = $urandom_range(0, 255); end
        endcase
      end
    end
  endtask

  // Any write strobed in the start cycle lands in the bank that is about to compute.
  task automatic do_start();
    if (we_a) ma[lb][int'(addr_a)] = int'(din_a);
    if (we_b) mb[lb][int'(addr_b)] = int'(din_b);
    model_result(lb);
    lb    = lb ^ 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    we_a  = 1'b0;
    we_b  = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("ovf_clear_after_start", int'(ovf), 0);
  endtask

  task automatic load_and_start();
    for (int idx = 0; idx < NN; idx++) begin
      we_a = 1'b1; addr_a = AW'(idx); din_a = DW'(pa[idx]);
      we_b = 1'b1; addr_b = AW'(idx); din_b = DW'(pb[idx]);
      if (idx == NN - 1) begin
        do_start();
      end else begin
        ma[lb][idx] = pa[idx];
        mb[lb][idx] = pb[idx];
        tick();
      end
    end
  endtask

  // done is seen 3N edges after the start edge (cycle T+3N+1).
  task automatic wait_done(input string nm, input int already);
    int lat;
    lat = already;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk(nm, lat, 3*N);
    if (done === 1'b1) begin
      mres = pend;
      movf = pend_ovf;
    end
  endtask

  task automatic finish_run(input string nm);
    chk($sformatf("%s_load_bank", nm), int'(load_bank), lb);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("%s_done_one_cycle", nm), int'(done), 0);
    chk($sformatf("%s_start_in_done_ignored", nm), int'(busy), 0);
    chk($sformatf("%s_load_bank_after_done", nm), int'(load_bank), lb);
    chk($sformatf("%s_ovf", nm), int'(ovf), movf);
  endtask

  task automatic read_all(input string nm);
    for (int idx = 0; idx < NN; idx++) begin
      c_addr = AW'(idx);
      tick();
      chk($sformatf("%s_c[%0d]", nm, idx), int'(c_data), mres[idx]);
    end
  endtask

  task automatic full_run(input string nm);
    load_and_start();
    wait_done({nm, "_latency"}, 0);
    finish_run(nm);
    read_all(nm);
  endtask

  initial begin
    int ndone, first, elapsed;
    n_checks = 0; n_pass = 0;
    lb = 0; movf = 0; pend_ovf = 0;
    for (int i = 0; i < NN; i++) begin
      mres[i] = 0; ma[0][i] = 0; ma[1][i] = 0; mb[0][i] = 0; mb[1][i] = 0;
    end
    vecs[0] = '{kind: 0, probe: 15, exp_probe: 64, exp_ovf: 0};
`ifdef SYSTOLIC_SAT_EN
    vecs[1] = '{kind: 1, probe: 0, exp_probe: 65535, exp_ovf: 1};
`else
    vecs[1] = '{kind: 1, probe: 0, exp_probe: 63492, exp_ovf: 0};
`endif
    vecs[2] = '{kind: 2, probe: 6, exp_probe: 3, exp_ovf: 0};
    vecs[3] = '{kind: 3, probe: 9, exp_probe: 10, exp_ovf: 0};

    rst = 1'b1; we_a = 1'b0; we_b = 1'b0; start = 1'b0;
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0; c_addr = '0;
    tick();
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_load_bank", int'(load_bank), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_c_data", int'(c_data), 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      fill_pattern(vecs[v].kind);
      load_and_start();
      wait_done($sformatf("vec%0d_latency", v), 0);
      finish_run($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_ovf_table", v), int'(ovf), vecs[v].exp_ovf);
      c_addr = AW'(vecs[v].probe);
      tick();
      chk($sformatf("vec%0d_probe", v), int'(c_data), vecs[v].exp_probe);
      read_all($sformatf("vec%0d", v));
    end

    for (int r = 0; r < 4; r++) begin
      fill_pattern((r < 2) ? 4 : 5);
      full_run($sformatf("rand%0d", r));
    end

    // Identity reload into the idle bank while the first product runs.
    fill_pattern(0);
    load_and_start();
    fill_pattern(2);
    ndone = 0; first = -1;
    c_addr = AW'(5);
    for (int idx = 0; idx < NN; idx++) begin
      we_a = 1'b1; addr_a = AW'(idx); din_a = DW'(pa[idx]); ma[lb][idx] = pa[idx];
      we_b = 1'b1; addr_b = AW'(idx); din_b = DW'(pb[idx]); mb[lb][idx] = pb[idx];
      tick();
      if (idx == 4) chk("old_result_during_compute", int'(c_data), mres[5]);
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = idx + 1;
        mres = pend;
        movf = pend_ovf;
      end
      if (idx == NN - 1) chk("new_result_after_done", int'(c_data), mres[5]);
    end
    we_a = 1'b0; we_b = 1'b0;
    chk("reload_done_count", ndone, 1);
    chk("reload_done_latency", first, 3*N);
    chk("reload_load_bank", int'(load_bank), lb);
    do_start();
    c_addr = AW'(0);
    tick(); tick(); tick();
    chk("first_result_held", int'(c_data), mres[0]);
    wait_done("identity_latency", 3);
    finish_run("identity");
    read_all("identity");

    // start pulse in cycle T+5 while busy must be ignored.
    fill_pattern(3);
    load_and_start();
    tick(); tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    elapsed = 5; ndone = 0; first = -1;
    while (elapsed < 24) begin
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = elapsed;
        mres = pend;
        movf = pend_ovf;
      end
      tick();
      elapsed++;
    end
    chk("busy_start_done_count", ndone, 1);
    chk("busy_start_done_latency", first, 3*N);
    chk("busy_start_load_bank", int'(load_bank), lb);
    chk("busy_start_idle", int'(busy), 0);
    read_all("busy_start");

    // Reset in cycle T+6 aborts the run and clears results but not operands.
    fill_pattern(5);
    load_and_start();
    tick(); tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_load_bank", int'(load_bank), 0);
    lb = 0; movf = 0;
    for (int i = 0; i < NN; i++) mres[i] = 0;
    ndone = 0;
    for (int t = 0; t < 16; t++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_ovf", int'(ovf), 0);
    read_all("abort");
    do_start();
    wait_done("retained_latency", 0);
    finish_run("retained");
    read_all("retained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_array_pp.md
SYSTOLIC_ARRAY_PP -- requirements
Module: systolic_array_pp

Interface
REQ-001 Parameter N, default 16: array dimension; computes C = A x B for NxN matrices, N >= 2.
REQ-002 Parameter DW, default 8: operand element width, unsigned.
REQ-003 Parameter ACCW, default 16: accumulator and result element width, unsigned.
REQ-004 AW = $clog2(N*N), derived: operand and result address width.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 we_a  in  1  write strobe for the A operand SRAM, load bank.
REQ-008 addr_a  in  AW  A address, row-major: i*N+k.
REQ-009 din_a  in  DW  A write data.
REQ-010 we_b  in  1  write strobe for the B operand SRAM, load bank.
REQ-011 addr_b  in  AW  B address, row-major: k*N+j.
REQ-012 din_b  in  DW  B write data.
REQ-013 start  in  1  compute request, sampled in IDLE only.
REQ-014 busy  out  1  high while a computation is in progress.
REQ-015 done  out  1  single-cycle pulse when the result buffer is updated.
REQ-016 load_bank  out  1  operand bank currently targeted by host writes.
REQ-017 c_addr  in  AW  result read address, row-major: i*N+j.
REQ-018 c_data  out  ACCW  result element; registered, one-cycle read latency.
REQ-019 ovf  out  1  sticky overflow flag for the last completed result.

Function
REQ-020 Operand SRAMs SHALL be double-banked (2 x N*N x DW each for A and B); host writes SHALL go only to bank load_bank.
REQ-021 FSM SHALL have states IDLE, COMPUTE, DONE; IDLE->COMPUTE on start, COMPUTE->DONE after its cycle count, DONE->IDLE unconditionally.
REQ-022 On start accepted at edge T: compute bank <= load_bank, load_bank toggles, PE accumulators clear, busy = 1 from T+1.
REQ-023 COMPUTE SHALL last exactly 3N cycles: 1 SRAM read cycle + 3N-1 skewed injection/propagation cycles.
REQ-024 Feed skew: row i of A enters PE(i,0) delayed by i cycles; column j of B enters PE(0,j) delayed by j cycles; zeros are injected outside each valid window.
REQ-025 Each PE SHALL register a/b to right/down neighbours and accumulate acc += a*b (DW x DW product, zero-extended to ACCW).
REQ-026 In DONE, the accumulators SHALL be copied into an N*N x ACCW result buffer, done = 1 for that one cycle, busy = 0 from the following cycle.
REQ-027 done SHALL assert on cycle T+3N+1; a new start is accepted on cycle T+3N+2 at the earliest.
REQ-028 start while busy or in DONE SHALL be ignored; no queuing.
REQ-029 Host writes during COMPUTE SHALL be accepted into load_bank and SHALL NOT disturb the running computation.
REQ-030 c_data SHALL always return the last completed result (old result during COMPUTE); an out-of-range c_addr SHALL return 0.
REQ-031 Simultaneous we_a/we_b and start in IDLE: the write lands in the old load_bank, which becomes the compute bank.

Reset
REQ-032 rst SHALL force IDLE, busy = 0, done = 0, load_bank = 0, ovf = 0, all accumulators and result buffer entries = 0, c_data = 0.
REQ-033 rst mid-COMPUTE SHALL abort without a done pulse; operand SRAM contents are not cleared.

Configuration
REQ-034 Macro SYSTOLIC_SAT_EN defined: accumulation saturates at 2^ACCW-1 per PE, and ovf latches 1 in DONE if any PE saturated; ovf clears on the next start.
REQ-035 SYSTOLIC_SAT_EN undefined: accumulation wraps modulo 2^ACCW, and ovf is constant 0.

Verification (N=4, DW=8, ACCW=16)
REQ-036 Load A[i][k]=i+1, B[k][j]=j+1 into bank 0, then start at T -> done at T+13, C[i][j]=4(i+1)(j+1), c_addr=15 -> 64, load_bank=1.
REQ-037 All A=B=255 -> without macro C[*]=63492 and ovf=0; with SYSTOLIC_SAT_EN C[*]=65535 and ovf=1.
REQ-038 Load identity into bank 1 during the first compute, B unchanged, then start after done -> C[i][j]=j+1; the first result is readable until the second done.
REQ-039 Pulse start at T+5 during busy -> ignored; exactly one done at T+13; load_bank unchanged.
REQ-040 rst at T+6 -> busy=0 next cycle, no done, c_data=0 for every c_addr, load_bank=0.
